// File: rtl/demux_rr_dispatcher.sv
`timescale 1ns/1ps
// demux_rr_dispatcher
// Shares one producer stream between eight consumer lanes. Each packet of
// PKT_LEN beats is granted to one enabled lane, lanes being visited in
// round-robin order starting after the previously served lane. Beats pass
// through a single-entry hold register, so out_valid/out_data are registered
// and a full-rate stream sustains one beat per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   producer has a beat
//   in_data    producer beat (DATA_W bits)
//   in_ready   beat accepted this cycle (combinational from dst_ready[sel])
//   dst_mask   per-lane enable, only looked at while arbitrating
//   dst_ready  per-lane ready; only the granted lane's bit matters
//   out_valid  one-hot valid, bit sel only
//   out_data   registered beat, broadcast to every lane
//   sel        granted lane index
//   busy       high while arbitrating or transferring
//   pkt_done   one-cycle pulse after the last beat of a packet is delivered
module demux_rr_dispatcher #(
  parameter int DATA_W  = 8,
  parameter int PKT_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [7:0]        dst_mask,
  input  logic [7:0]        dst_ready,
  output logic [7:0]        out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        sel,
  output logic              busy,
  output logic              pkt_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  localparam logic [7:0] PKT_LEN_C   = 8'(PKT_LEN);
  localparam logic [7:0] LAST_BEAT_C = 8'(PKT_LEN - 1);

  // Round-robin search: first enabled lane after 'last', wrapping, with 'last'
  // itself checked at the very end. Bit 3 of the result flags a hit.
  function automatic logic [3:0] rr_pick(input logic [7:0] mask, input logic [2:0] last);
    logic [3:0] pick;
    logic [2:0] cand;
    pick = 4'd0;
    for (int k = 1; k <= 8; k++) begin
      cand = last + 3'(k);
      pick = (!pick[3] && mask[cand]) ? {1'b1, cand} : pick;
    end
    return pick;
  endfunction

  state_t            state_r, state_nxt_s;
  logic [2:0]        sel_r, sel_nxt_s;
  logic [2:0]        last_sel_r, last_sel_nxt_s;
  logic              hold_full_r, hold_full_nxt_s;
  logic [DATA_W-1:0] out_data_r, out_data_nxt_s;
  logic [7:0]        out_valid_r, out_valid_nxt_s;
  logic [7:0]        acc_cnt_r, acc_cnt_nxt_s;
  logic [7:0]        tx_cnt_r, tx_cnt_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              pkt_done_r, pkt_done_nxt_s;
  logic              in_ready_s;
  logic              deliver_s;
  logic              accept_s;
  logic [3:0]        pick_s;

  // Next-state, counter and hold-register update logic.
  always_comb begin
    state_nxt_s     = state_r;
    sel_nxt_s       = sel_r;
    last_sel_nxt_s  = last_sel_r;
    hold_full_nxt_s = hold_full_r;
    out_data_nxt_s  = out_data_r;
    acc_cnt_nxt_s   = acc_cnt_r;
    tx_cnt_nxt_s    = tx_cnt_r;
    pkt_done_nxt_s  = 1'b0;
    in_ready_s      = 1'b0;
    deliver_s       = 1'b0;
    accept_s        = 1'b0;
    pick_s          = rr_pick(dst_mask, last_sel_r);

    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt_s = ST_ARB;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_ARB: begin
        if (pick_s[3]) begin
          state_nxt_s   = ST_XFER;
          sel_nxt_s     = pick_s[2:0];
          acc_cnt_nxt_s = 8'd0;
          tx_cnt_nxt_s  = 8'd0;
        end else begin
          state_nxt_s = ST_ARB;
        end
      end

      ST_XFER: begin
        deliver_s  = hold_full_r & dst_ready[sel_r];
        // Room exists when the hold register is empty or drains this cycle.
        in_ready_s = (acc_cnt_r < PKT_LEN_C) & (!hold_full_r | dst_ready[sel_r]);
        accept_s   = in_valid & in_ready_s;
        hold_full_nxt_s = accept_s | (hold_full_r & !deliver_s);

        if (accept_s) begin
          out_data_nxt_s = in_data;
          acc_cnt_nxt_s  = acc_cnt_r + 8'd1;
        end else begin
          out_data_nxt_s = out_data_r;
          acc_cnt_nxt_s  = acc_cnt_r;
        end

        if (deliver_s) begin
          tx_cnt_nxt_s = tx_cnt_r + 8'd1;
          if (tx_cnt_r == LAST_BEAT_C) begin
            state_nxt_s    = ST_IDLE;
            last_sel_nxt_s = sel_r;
            pkt_done_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_XFER;
          end
        end else begin
          tx_cnt_nxt_s = tx_cnt_r;
        end
      end

      default: begin
        state_nxt_s     = ST_IDLE;
        hold_full_nxt_s = 1'b0;
      end
    endcase

    busy_nxt_s      = (state_nxt_s != ST_IDLE);
    out_valid_nxt_s = hold_full_nxt_s ? (8'b1 << sel_nxt_s) : 8'b0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      sel_r       <= 3'd0;
      last_sel_r  <= 3'd7;
      hold_full_r <= 1'b0;
      out_data_r  <= '0;
      out_valid_r <= 8'd0;
      acc_cnt_r   <= 8'd0;
      tx_cnt_r    <= 8'd0;
      busy_r      <= 1'b0;
      pkt_done_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      sel_r       <= sel_nxt_s;
      last_sel_r  <= last_sel_nxt_s;
      hold_full_r <= hold_full_nxt_s;
      out_data_r  <= out_data_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      acc_cnt_r   <= acc_cnt_nxt_s;
      tx_cnt_r    <= tx_cnt_nxt_s;
      busy_r      <= busy_nxt_s;
      pkt_done_r  <= pkt_done_nxt_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign sel       = sel_r;
  assign busy      = busy_r;
  assign pkt_done  = pkt_done_r;

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
`timescale 1ns/1ps
// Bench for demux_rr_dispatcher: directed scenarios with cycle-exact
// expectations, a PKT_LEN=1 instance for the minimum packet period, and a
// randomized phase checked against a transaction-level model (queue of
// accepted beats, round-robin lane choice computed from the mask).
module tb_demux_rr_dispatcher;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] dst_mask;
  logic [7:0] dst_ready;
  logic [7:0] out_valid;
  logic [7:0] out_data;
  logic [2:0] sel;
  logic       busy;
  logic       pkt_done;

  logic       u1_in_valid;
  logic [7:0] u1_in_data;
  logic       u1_in_ready;
  logic [7:0] u1_dst_mask;
  logic [7:0] u1_dst_ready;
  logic [7:0] u1_out_valid;
  logic [7:0] u1_out_data;
  logic [2:0] u1_sel;
  logic       u1_busy;
  logic       u1_pkt_done;

  int checks = 0;
  int errors = 0;

  demux_rr_dispatcher #(.DATA_W(8), .PKT_LEN(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .dst_mask(dst_mask), .dst_ready(dst_ready),
    .out_valid(out_valid), .out_data(out_data), .sel(sel), .busy(busy),
    .pkt_done(pkt_done)
  );

  demux_rr_dispatcher #(.DATA_W(8), .PKT_LEN(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(u1_in_valid), .in_data(u1_in_data),
    .in_ready(u1_in_ready), .dst_mask(u1_dst_mask), .dst_ready(u1_dst_ready),
    .out_valid(u1_out_valid), .out_data(u1_out_data), .sel(u1_sel), .busy(u1_busy),
    .pkt_done(u1_pkt_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    u1_in_valid = 1'b0;
    adv();
    adv();
    rst = 1'b0;
  endtask

  function automatic int rr(input int last, input logic [7:0] m);
    for (int k = 1; k <= 8; k++) begin
      if (m[(last + k) % 8]) return (last + k) % 8;
    end
    return -1;
  endfunction

  // Full-rate streaming check: with continuous traffic and all lanes ready a
  // packet occupies 7 cycles (IDLE, ARB, 4 accepts overlapping 4 deliveries,
  // then the pkt_done cycle which is IDLE again).
  int exp_lanes[$];
  task automatic stream_check(input int npkt, input string tg);
    int dcnt;
    int p;
    int r;
    logic [7:0] eov;
    logic [31:0] ed;
    bit epd;
    bit eir;
    dcnt = 1;
    for (int c = 0; c <= 7 * npkt; c++) begin
      in_data = 8'(dcnt);
      @(negedge clk);
      eov = 8'h00; ed = 32'd0; epd = 1'b0; eir = 1'b0;
      if (c >= 3) begin
        p = (c - 3) / 7; r = (c - 3) % 7;
        if (p < npkt && r < 4) begin
          eov = 8'b1 << exp_lanes[p];
          ed  = 32'(4 * p + r + 1);
        end
        if (p < npkt && r == 4) epd = 1'b1;
      end
      if (c >= 2) begin
        p = (c - 2) / 7; r = (c - 2) % 7;
        if (p < npkt && r < 4) eir = 1'b1;
      end
      chk({tg, "_ov"}, 32'(out_valid), 32'(eov));
      chk({tg, "_ir"}, 32'(in_ready), 32'(eir));
      chk({tg, "_pd"}, 32'(pkt_done), 32'(epd));
      if (eov != 8'h00) begin
        chk({tg, "_data"}, 32'(out_data), ed);
        chk({tg, "_sel"}, 32'(sel), 32'(exp_lanes[(c - 3) / 7]));
      end
      if (in_valid && in_ready) dcnt++;
      adv();
    end
  endtask

  // Transaction-level reference model for the random phase.
  logic [7:0] m_q[$];
  int m_last, m_lane, m_acc, m_tx, m_done;
  bit m_active, m_pd;
  logic [7:0] pkt_mask;

  task automatic rstep();
    logic [7:0] eov;
    bit dlv, acc, ok;
    @(negedge clk);
    eov = (m_q.size() != 0) ? (8'b1 << m_lane) : 8'h00;
    chk("rnd_ov", 32'(out_valid), 32'(eov));
    chk("rnd_pd", 32'(pkt_done), 32'(m_pd));
    if (m_q.size() != 0) begin
      chk("rnd_data", 32'(out_data), 32'(m_q[0]));
      chk("rnd_sel", 32'(sel), 32'(m_lane));
      chk("rnd_busy", 32'(busy), 32'd1);
    end
    if (in_ready) begin
      ok = (m_acc < 4) && (m_q.size() == 0 || dst_ready[m_lane]);
      chk("rnd_ir", 32'(ok), 32'd1);
    end
    m_pd = 1'b0;
    dlv = (m_q.size() != 0) && dst_ready[m_lane];
    acc = in_valid && in_ready;
    if (dlv) begin
      void'(m_q.pop_front());
      m_tx++;
      if (m_tx == 4) begin
        m_pd = 1'b1; m_last = m_lane; m_active = 1'b0; m_acc = 0; m_done++;
      end
    end
    if (acc) begin
      if (!m_active) begin
        m_active = 1'b1; m_lane = rr(m_last, pkt_mask); m_acc = 0; m_tx = 0;
      end
      m_q.push_back(in_data);
      m_acc++;
    end
    adv();
  endtask

  logic [7:0] t3_ov [0:10];
  logic [7:0] t3_d  [0:10];
  logic       t3_ir [0:10];
  logic [7:0] t3_dr [0:10];

  initial begin
    int dcnt;
    int d0;
    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; dst_mask = 8'hFF; dst_ready = 8'hFF;
    u1_in_valid = 1'b0; u1_in_data = 8'h00; u1_dst_mask = 8'hFF; u1_dst_ready = 8'hFF;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ir", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pd", 32'(pkt_done), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    adv();

    // Full mask: lanes 0..7 then back to 0
    do_reset();
    dst_mask = 8'hFF; dst_ready = 8'hFF; in_valid = 1'b1;
    exp_lanes = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    stream_check(9, "rr_all");

    // Sparse mask: 2,5,7,2
    do_reset();
    dst_mask = 8'b1010_0100; in_valid = 1'b1;
    exp_lanes = '{2, 5, 7, 2};
    stream_check(4, "rr_sparse");

    // Backpressure on lane 3: beat 2 held for 3 cycles
    t3_ov = '{8'h00, 8'h00, 8'h00, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h00};
    t3_d  = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h03, 8'h04, 8'h00};
    t3_ir = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    t3_dr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF7, 8'hF7, 8'hF7, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_reset();
    dst_mask = 8'h08; in_valid = 1'b1; dcnt = 1;
    for (int c = 0; c <= 10; c++) begin
      in_data = 8'(dcnt);
      dst_ready = t3_dr[c];
      @(negedge clk);
      chk("bp_ov", 32'(out_valid), 32'(t3_ov[c]));
      chk("bp_ir", 32'(in_ready), 32'(t3_ir[c]));
      chk("bp_pd", 32'(pkt_done), (c == 10) ? 32'd1 : 32'd0);
      if (t3_ov[c] != 8'h00) begin
        chk("bp_data", 32'(out_data), 32'(t3_d[c]));
        chk("bp_sel", 32'(sel), 32'd3);
      end
      if (in_valid && in_ready) dcnt++;
      adv();
    end
    dst_ready = 8'hFF;

    // Empty mask: parked in ARB until lane 4 is enabled
    do_reset();
    dst_mask = 8'h00; in_valid = 1'b1; in_data = 8'h5A;
    @(negedge clk);
    chk("m0_busy_idle", 32'(busy), 32'd0);
    adv();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("m0_busy", 32'(busy), 32'd1);
      chk("m0_ir", 32'(in_ready), 32'd0);
      chk("m0_ov", 32'(out_valid), 32'd0);
      chk("m0_sel", 32'(sel), 32'd0);
      adv();
    end
    dst_mask = 8'h10;
    adv();
    @(negedge clk);
    chk("m0_grant_sel", 32'(sel), 32'd4);
    chk("m0_grant_ir", 32'(in_ready), 32'd1);
    adv();
    @(negedge clk);
    chk("m0_ov4", 32'(out_valid), 32'h10);
    chk("m0_data", 32'(out_data), 32'h5A);
    adv();

    // Reset in the middle of a lane-6 packet
    do_reset();
    dst_mask = 8'h40; in_valid = 1'b1; dcnt = 1;
    for (int c = 0; c <= 4; c++) begin
      in_data = 8'(dcnt);
      @(negedge clk);
      if (c >= 3) begin
        chk("mr_ov", 32'(out_valid), 32'h40);
        chk("mr_data", 32'(out_data), 32'(c - 2));
      end
      if (in_valid && in_ready) dcnt++;
      adv();
    end
    rst = 1'b1;
    adv();
    rst = 1'b0; dst_mask = 8'hFF;
    @(negedge clk);
    chk("mr_ov_rst", 32'(out_valid), 32'd0);
    chk("mr_busy_rst", 32'(busy), 32'd0);
    chk("mr_pd_rst", 32'(pkt_done), 32'd0);
    chk("mr_ir_rst", 32'(in_ready), 32'd0);
    adv();
    @(negedge clk);
    chk("mr_arb_pd", 32'(pkt_done), 32'd0);
    adv();
    @(negedge clk);
    chk("mr_next_sel", 32'(sel), 32'd0);
    chk("mr_next_ir", 32'(in_ready), 32'd1);
    adv();
    @(negedge clk);
    chk("mr_next_ov", 32'(out_valid), 32'h01);
    adv();

    // Mask change during transfer on lane 2
    do_reset();
    dst_mask = 8'h04; in_valid = 1'b1; dcnt = 1;
    for (int c = 0; c <= 10; c++) begin
      in_data = 8'(dcnt);
      if (c == 2) dst_mask = 8'hFF;
      if (c == 4) dst_mask = 8'h01;
      @(negedge clk);
      if (c >= 3 && c <= 6) begin
        chk("mc_ov", 32'(out_valid), 32'h04);
        chk("mc_data", 32'(out_data), 32'(c - 2));
      end
      if (c == 7) chk("mc_pd", 32'(pkt_done), 32'd1);
      if (c == 9) chk("mc_sel", 32'(sel), 32'd0);
      if (c == 10) chk("mc_ov0", 32'(out_valid), 32'h01);
      if (in_valid && in_ready) dcnt++;
      adv();
    end

    // PKT_LEN=1 instance: 4-cycle packet period
    do_reset();
    in_valid = 1'b0;
    u1_in_valid = 1'b1; u1_dst_mask = 8'hFF; u1_dst_ready = 8'hFF; dcnt = 1;
    for (int c = 0; c <= 36; c++) begin
      u1_in_data = 8'(dcnt);
      @(negedge clk);
      if (c >= 3 && (c - 3) % 4 == 0) begin
        chk("p1_ov", 32'(u1_out_valid), 32'(8'b1 << (((c - 3) / 4) % 8)));
        chk("p1_data", 32'(u1_out_data), 32'((c - 3) / 4 + 1));
      end else begin
        chk("p1_ov0", 32'(u1_out_valid), 32'd0);
      end
      chk("p1_pd", 32'(u1_pkt_done), (c >= 4 && (c - 4) % 4 == 0) ? 32'd1 : 32'd0);
      if (u1_in_valid && u1_in_ready) dcnt++;
      adv();
    end
    u1_in_valid = 1'b0;

    // Randomized traffic against the reference model
    do_reset();
    m_q.delete();
    m_last = 7; m_lane = 0; m_acc = 0; m_tx = 0; m_done = 0; m_active = 1'b0; m_pd = 1'b0;
    for (int n = 0; n < 40; n++) begin
      in_valid = 1'b0;
      pkt_mask = 8'($urandom_range(1, 255));
      dst_mask = pkt_mask;
      dst_ready = 8'($urandom);
      rstep();
      d0 = m_done;
      for (int c = 0; c < 300 && m_done == d0; c++) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_data = 8'($urandom);
        dst_ready = 8'($urandom);
        dst_mask = m_active ? 8'($urandom) : pkt_mask;
        rstep();
      end
      chk("rnd_pkt_complete", 32'(m_done), 32'(d0 + 1));
    end
    in_valid = 1'b0;
    rstep();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_rr_dispatcher.md
Name: demux_rr_dispatcher

Overview:
- Packet dispatcher that shares one input stream between 8 destinations.
- Grants each packet of PKT_LEN beats to one enabled destination, in round-robin order.
- Drives a registered 1-to-8 demultiplexed output: one-hot valid, broadcast data, with per-destination ready backpressure.
- Sits between a single producer and eight consumer lanes.
- Exports `sel` so an external demux or monitor can track the current grant.

Parameters:
- DATA_W, 8: width of in_data / out_data.
- PKT_LEN, 4: beats per packet. Legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a beat.
- in_data  in  DATA_W  producer beat.
- in_ready  out  1  dispatcher accepts the beat this cycle.
- dst_mask  in  8  destination enables; sampled only in ARB.
- dst_ready  in  8  per-destination ready.
- out_valid  out  8  one-hot valid; only bit `sel` may be 1.
- out_data  out  DATA_W  registered beat, broadcast to all lanes.
- sel  out  3  index of the granted destination.
- busy  out  1  high in ARB and XFER.
- pkt_done  out  1  one-cycle pulse after the last beat of a packet is delivered.

Behaviour:
- Reset (rst=1 at a clock edge, from any state, including mid-packet):
  - state=IDLE.
  - sel=0, last_sel=7 (so the first search starts at index 0).
  - out_valid=0, out_data=0, in_ready=0, busy=0, pkt_done=0.
  - acc_cnt=0, tx_cnt=0, hold register empty.
  - Any partially transferred packet is discarded; no pkt_done is generated.
- States: IDLE, ARB, XFER.
- IDLE:
  - in_ready=0, busy=0.
  - in_valid=1 → ARB next cycle.
- ARB (one cycle minimum):
  - Search indices (last_sel+1)..(last_sel+8) mod 8; pick the first i with dst_mask[i]=1.
  - dst_ready is not considered in the search.
  - On a hit: sel<=i, acc_cnt<=0, tx_cnt<=0, → XFER.
  - dst_mask=0: stay in ARB, sel unchanged, in_ready=0.
  - in_ready=0 throughout ARB.
- XFER:
  - Hold register holds 0 or 1 beat. out_valid[sel]=hold_full; all other bits 0.
  - Delivery: hold_full & dst_ready[sel].
  - in_ready = (acc_cnt<PKT_LEN) & (!hold_full | dst_ready[sel]). This is combinational from dst_ready[sel].
  - Accept (in_valid & in_ready): in_data is loaded into the hold register and acc_cnt increments. The accepted beat appears on out_data/out_valid the next cycle (latency 1).
  - Simultaneous delivery and accept: hold stays full with the new beat, giving 1 beat/cycle sustained throughput.
  - Each delivery increments tx_cnt.
  - Delivery that makes tx_cnt==PKT_LEN:
    - next cycle: state=IDLE, last_sel<=sel, out_valid=0, pkt_done=1 for exactly one cycle;
    - sel holds its value until the next ARB.
  - dst_ready for non-selected lanes is ignored.
  - dst_mask changes during XFER have no effect.
  - dst_ready[sel] low: hold the beat, out_data stable, out_valid stays high (no retraction).
- Counters:
  - acc_cnt and tx_cnt are 8-bit and never exceed PKT_LEN. No wrap is possible.
  - last_sel wraps 7→0 in the search.
- Round-robin with mask = 8'hFF visits 0,1,…,7,0.
- A destination whose mask bit drops is skipped from the next ARB onward.
- PKT_LEN=1:
  - ARB→XFER; one accept, one delivery, then IDLE.
  - Minimum packet period is 4 cycles (IDLE, ARB, XFER accept, XFER deliver).
- busy=1 in ARB and XFER; 0 in IDLE and during reset.

Test Plan:
- Reset, then mask=8'hFF, dst_ready=8'hFF, in_valid held 1, PKT_LEN=4, data 0x01,0x02,… → packet 1 on lane 0 (out_valid=8'h01, data 0x01–0x04 on 4 consecutive cycles), pkt_done pulse, next packet on lane 1 (out_valid=8'h02, data 0x05–0x08); 8 packets cover lanes 0..7, the ninth returns to lane 0.
- mask=8'b1010_0100 with continuous traffic → grant order 2,5,7,2; lanes 0,1,3,4,6 never see out_valid.
- Lane 3 granted; drop dst_ready[3] for 3 cycles after beat 2 → out_valid=8'h08 and out_data=beat 2 held stable; in_ready=0; no loss or duplication; tx completes 4 beats in order.
- mask=0 with in_valid=1 → stays in ARB, busy=1, in_ready=0, out_valid=0; set mask=8'h10 → grant lane 4 the next cycle.
- Assert rst after beat 2 of a 4-beat packet on lane 6 → next cycle out_valid=0, busy=0, pkt_done=0; following packet granted to lane 0 (last_sel reset to 7).
- Change mask from 8'hFF to 8'h01 mid-XFER on lane 2 → lane 2 packet completes all 4 beats; next grant is lane 0.
